// File: rtl/multicycle_ctrl_unit_pkg.sv
// Shared types for the multi-cycle RV32I control unit: FSM states, opcode
// constants, ALU operation encodings and the per-state control word.
package multicycle_ctrl_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } aluop_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore control word held in a register alongside the state.
  // gate_ready marks states whose pcwrite/irwrite wait for mem_ready;
  // branch marks the state whose pcwrite comes from the compare result.
  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    aluop_t     aluop;
    logic       branch;
    logic       gate_ready;
  } ctl_t;

  function automatic ctl_t state_ctl(state_t s);
    ctl_t c;
    c = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1; c.irwrite = 1'b1; c.pcwrite = 1'b1;
        c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.gate_ready = 1'b1;
      end
      S_DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      S_MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      S_MEMREAD:  begin c.adrsrc = 1'b1; c.memread = 1'b1; end
      S_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      S_EXECR:    begin c.alusrca = 2'b10; c.aluop = ALUOP_FUNCT; end
      S_EXECI: begin
        c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = ALUOP_FUNCT;
      end
      S_ALUWB:    c.regwrite = 1'b1;
      S_BRANCH:   begin c.alusrca = 2'b10; c.aluop = ALUOP_BRANCH; c.branch = 1'b1; end
      S_JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcwrite = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] imm_for(logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

  // funct3 values 010/011 are not branches.
  function automatic logic branch_f3_legal(logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

  function automatic logic branch_taken(logic [2:0] f3, logic zero, logic lt);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return lt;
      3'b111:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_unit_if.sv
// Control-unit bundle: instruction fields and datapath flags in, every
// datapath enable and mux select out. master = control unit, slave = datapath.
interface multicycle_ctrl_unit_if #(
  parameter int ALUCTRL_W = 4,
  parameter int STATE_W   = 4
) ();
  logic [6:0]           opcode;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic                 zero;
  logic                 lt;
  logic                 mem_ready;
  logic                 pcwrite;
  logic                 adrsrc;
  logic                 memread;
  logic                 memwrite;
  logic                 irwrite;
  logic                 regwrite;
  logic [1:0]           resultsrc;
  logic [1:0]           alusrca;
  logic [1:0]           alusrcb;
  logic [1:0]           immsrc;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic                 illegal;
  logic [STATE_W-1:0]   state;

  modport master (
    input  opcode, f3, f7, zero, lt, mem_ready,
    output pcwrite, adrsrc, memread, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, immsrc, alucontrol, illegal, state
  );

  modport slave (
    output opcode, f3, f7, zero, lt, mem_ready,
    input  pcwrite, adrsrc, memread, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, immsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl_unit_aludeco.sv
// ALU decoder: maps aluop plus funct fields to an ALU operation.
module aludeco
  import multicycle_ctrl_unit_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] f3,
  input  logic       f7b5,
  input  logic       opb5,
  output alu_ctrl_t  alucontrol
);

  // Select the ALU operation for the current aluop and funct fields.
  always_comb begin
    // NOTE: default assigned first so every path drives alucontrol and no latch is inferred.
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_BRANCH: begin
        case (f3[2:1])
          2'b10:   alucontrol = ALU_SLT;
          2'b11:   alucontrol = ALU_SLTU;
          default: alucontrol = ALU_SUB;
        endcase
      end
      ALUOP_FUNCT: begin
        case (f3)
          // sub only for R-type (opcode bit 5 set); addi ignores funct7
          3'b000:  alucontrol = (opb5 && f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle RV32I control unit: registered FSM sequencing each
// instruction through a shared memory port and ALU with wait states.
module multicycle_ctrl_unit
  import multicycle_ctrl_unit_pkg::*;
#(
  parameter int ALUCTRL_W  = 4,
  parameter bit ENABLE_JAL = 1'b1,
  parameter int STATE_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_ctrl_unit_if.master bus
);

  state_t    state_q, state_d;
  ctl_t      ctl_q;
  logic      illegal_q, bad_d;
  alu_ctrl_t alu_ctrl;
  logic      mem_go;
  logic      taken;
  logic      unused_f7;

  // Next state and undecodable-instruction detection.
  always_comb begin
    state_d = state_q;
    bad_d   = 1'b0;
    case (state_q)
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH: begin
            state_d = S_BRANCH;
            bad_d   = !branch_f3_legal(bus.f3);
          end
          OP_JAL: begin
            if (ENABLE_JAL) begin
              state_d = S_JAL;
            end else begin
              state_d = S_FETCH;
              bad_d   = 1'b1;
            end
          end
          default: begin
            state_d = S_FETCH;
            bad_d   = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with its Moore control word and the illegal pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctl_q     <= state_ctl(S_FETCH);
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so state, control word and pulse all update from pre-edge values.
      state_q   <= state_d;
      ctl_q     <= state_ctl(state_d);
      illegal_q <= bad_d;
    end
  end

  aludeco u_aludeco (
    .aluop      (ctl_q.aluop),
    .f3         (bus.f3),
    .f7b5       (bus.f7[5]),
    .opb5       (bus.opcode[5]),
    .alucontrol (alu_ctrl)
  );

  // Only funct7 bit 5 selects an ALU operation.
  assign unused_f7 = ^{bus.f7[6], bus.f7[4:0]};

  // Fetch enables only fire in the cycle memory completes; branch writes
  // the PC from the same-cycle compare. rst_n masks every request and
  // write enable so reset takes effect without waiting for a clock.
  assign mem_go = !ctl_q.gate_ready || bus.mem_ready;
  assign taken  = ctl_q.branch && branch_taken(bus.f3, bus.zero, bus.lt);

  assign bus.pcwrite    = rst_n && ((ctl_q.pcwrite && mem_go) || taken);
  assign bus.irwrite    = rst_n && ctl_q.irwrite && mem_go;
  assign bus.memread    = rst_n && ctl_q.memread;
  assign bus.memwrite   = rst_n && ctl_q.memwrite;
  assign bus.regwrite   = rst_n && ctl_q.regwrite;
  assign bus.adrsrc     = ctl_q.adrsrc;
  assign bus.resultsrc  = ctl_q.resultsrc;
  assign bus.alusrca    = ctl_q.alusrca;
  assign bus.alusrcb    = ctl_q.alusrcb;
  assign bus.immsrc     = imm_for(bus.opcode);
  assign bus.alucontrol = ALUCTRL_W'(alu_ctrl);
  assign bus.illegal    = illegal_q;
  assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Self-checking bench for multicycle_ctrl_unit: a per-instruction model builds
// the expected cycle-by-cycle outputs from the instruction class and the
// memory wait pattern, then the DUT is stepped and compared each cycle.
module tb_multicycle_ctrl_unit;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic [6:0] LUI = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = LW;
  logic [2:0] f3 = 3'b010;
  logic [6:0] f7 = 7'b0;
  logic       zero = 1'b0;
  logic       lt = 1'b0;
  logic       mem_ready = 1'b1;

  always #5 clk = ~clk;

  multicycle_ctrl_unit_if #(.ALUCTRL_W(4), .STATE_W(4)) bus_a ();
  multicycle_ctrl_unit_if #(.ALUCTRL_W(4), .STATE_W(4)) bus_b ();

  assign bus_a.opcode = opcode;    assign bus_b.opcode = opcode;
  assign bus_a.f3 = f3;            assign bus_b.f3 = f3;
  assign bus_a.f7 = f7;            assign bus_b.f7 = f7;
  assign bus_a.zero = zero;        assign bus_b.zero = zero;
  assign bus_a.lt = lt;            assign bus_b.lt = lt;
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.mem_ready = mem_ready;

  multicycle_ctrl_unit #(.ALUCTRL_W(4), .ENABLE_JAL(1'b1), .STATE_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.master)
  );
  multicycle_ctrl_unit #(.ALUCTRL_W(4), .ENABLE_JAL(1'b0), .STATE_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.master)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, rw, mr, mw, irw, adr, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [3:0] aluc;
  } obs_t;

  typedef struct packed {
    logic rdy;
    obs_t o;
  } cyc_t;

  obs_t obs_a, obs_b;
  assign obs_a = {bus_a.state, bus_a.pcwrite, bus_a.regwrite, bus_a.memread,
                  bus_a.memwrite, bus_a.irwrite, bus_a.adrsrc, bus_a.illegal,
                  bus_a.resultsrc, bus_a.alusrca, bus_a.alusrcb, bus_a.immsrc,
                  bus_a.alucontrol};
  assign obs_b = {bus_b.state, bus_b.pcwrite, bus_b.regwrite, bus_b.memread,
                  bus_b.memwrite, bus_b.irwrite, bus_b.adrsrc, bus_b.illegal,
                  bus_b.resultsrc, bus_b.alusrca, bus_b.alusrcb, bus_b.immsrc,
                  bus_b.alucontrol};

  int   total = 0;
  int   bad = 0;
  cyc_t exp_q[$];
  logic ill_pending = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_imm(logic [6:0] op);
    if (op == SW) return 2'b01;
    if (op == BR) return 2'b10;
    if (op == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [3:0] ref_funct(logic [6:0] op, logic [2:0] fn3, logic [6:0] fn7);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
    if (fn3 == 3'b000 && op == RT && fn7[5]) return 4'd1;
    if (fn3 == 3'b101 && fn7[5]) return 4'd8;
    return tbl[fn3];
  endfunction

  // Memory-ready is a don't-care outside memory states, so randomise it there.
  function automatic cyc_t blank(logic [3:0] st, logic [6:0] op);
    cyc_t c;
    c = '0;
    c.o.st  = st;
    c.o.imm = ref_imm(op);
    c.rdy   = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // An undecodable instruction shows up as illegal in the cycle after DECODE.
  task automatic push(cyc_t c);
    c.o.ill = ill_pending;
    ill_pending = 1'b0;
    exp_q.push_back(c);
  endtask

  task automatic push_aluwb(logic [6:0] op);
    cyc_t c;
    c = blank(4'd8, op);
    c.o.rw = 1'b1;
    push(c);
  endtask

  task automatic build(logic [6:0] op, logic [2:0] fn3, logic [6:0] fn7,
                       logic z, logic l, int fw, int mw, bit jal_en);
    cyc_t c;
    for (int w = 0; w <= fw; w++) begin
      c = blank(4'd0, op);
      c.rdy = (w == fw);
      c.o.mr = 1'b1; c.o.irw = c.rdy; c.o.pcw = c.rdy;
      c.o.rs = 2'b10; c.o.sb = 2'b10;
      push(c);
    end
    c = blank(4'd1, op);
    c.o.sa = 2'b01; c.o.sb = 2'b01;
    push(c);
    case (op)
      LW, SW: begin
        c = blank(4'd2, op);
        c.o.sa = 2'b10; c.o.sb = 2'b01;
        push(c);
        for (int w = 0; w <= mw; w++) begin
          c = blank((op == LW) ? 4'd3 : 4'd5, op);
          c.rdy = (w == mw);
          c.o.adr = 1'b1;
          if (op == LW) c.o.mr = 1'b1; else c.o.mw = 1'b1;
          push(c);
        end
        if (op == LW) begin
          c = blank(4'd4, op);
          c.o.rs = 2'b01; c.o.rw = 1'b1;
          push(c);
        end
      end
      RT, IT: begin
        c = blank((op == RT) ? 4'd6 : 4'd7, op);
        c.o.sa = 2'b10;
        c.o.sb = (op == RT) ? 2'b00 : 2'b01;
        c.o.aluc = ref_funct(op, fn3, fn7);
        push(c);
        push_aluwb(op);
      end
      BR: begin
        ill_pending = (fn3[2:1] == 2'b01);
        c = blank(4'd9, op);
        c.o.sa = 2'b10;
        c.o.aluc = fn3[2] ? (fn3[1] ? 4'd9 : 4'd5) : 4'd1;
        c.o.pcw = !ill_pending && ((fn3[2] ? l : z) ^ fn3[0]);
        push(c);
      end
      JL: begin
        if (jal_en) begin
          c = blank(4'd10, op);
          c.o.sa = 2'b01; c.o.sb = 2'b10; c.o.pcw = 1'b1;
          push(c);
          push_aluwb(op);
        end else begin
          ill_pending = 1'b1;
        end
      end
      default: ill_pending = 1'b1;
    endcase
  endtask

  // Step the DUT through queued expectations; entered and left at posedge+1.
  task automatic run(string name, int sel, int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      cyc_t c;
      obs_t got;
      c = exp_q.pop_front();
      mem_ready = c.rdy;
      @(negedge clk);
      got = (sel != 0) ? obs_b : obs_a;
      total++;
      if (got !== c.o) begin
        bad++;
        $display("FAIL %s cycle %0d: got=%h expected=%h", name, n, got, c.o);
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic instr(string name, logic [6:0] op, logic [2:0] fn3, logic [6:0] fn7,
                       logic z, logic l, int fw, int mw, int sel);
    opcode = op; f3 = fn3; f7 = fn7; zero = z; lt = l;
    build(op, fn3, fn7, z, l, fw, mw, sel == 0);
    run(name, sel, 1000);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ill_pending = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [9:0] got;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus_a.state, bus_a.pcwrite, bus_a.irwrite, bus_a.regwrite,
           bus_a.memread, bus_a.memwrite, bus_a.illegal};
    total++;
    if (got !== 10'b0) begin
      bad++;
      $display("FAIL reset_a: got=%b expected=%b", got, 10'b0);
    end
    got = {bus_b.state, bus_b.pcwrite, bus_b.irwrite, bus_b.regwrite,
           bus_b.memread, bus_b.memwrite, bus_b.illegal};
    total++;
    if (got !== 10'b0) begin
      bad++;
      $display("FAIL reset_b: got=%b expected=%b", got, 10'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ill_pending = 1'b0;
  endtask

  task automatic test_lw();
    instr("lw", LW, 3'b010, 7'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_sw_wait();
    instr("sw_wait", SW, 3'b010, 7'b0, 1'b0, 1'b0, 0, 2, 0);
    instr("lw_wait", LW, 3'b010, 7'b0, 1'b0, 1'b0, 2, 1, 0);
  endtask

  task automatic test_branch();
    instr("bne_taken", BR, 3'b001, 7'b0, 1'b0, 1'b0, 0, 0, 0);
    instr("bne_not", BR, 3'b001, 7'b0, 1'b1, 1'b0, 0, 0, 0);
    instr("bgeu_taken", BR, 3'b111, 7'b0, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      instr("branch_f3", BR, 3'(i), 7'b0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 0, 0, 0);
    instr("after_branch", IT, 3'b000, 7'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_alu();
    for (int i = 0; i < 8; i++) begin
      instr("rtype", RT, 3'(i), 7'b0100000, 1'b0, 1'b0, 0, 0, 0);
      instr("rtype", RT, 3'(i), 7'b0000000, 1'b0, 1'b0, 0, 0, 0);
      instr("itype", IT, 3'(i), 7'b0100000, 1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  task automatic test_jal();
    instr("jal", JL, 3'($urandom), 7'($urandom), 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_illegal();
    instr("illegal", BAD, 3'b000, 7'b0, 1'b0, 1'b0, 0, 0, 0);
    instr("illegal_next", IT, 3'b000, 7'b0, 1'b0, 1'b0, 0, 0, 0);
    instr("lui_illegal", LUI, 3'b000, 7'b0, 1'b0, 1'b0, 1, 0, 0);
    instr("illegal_next2", RT, 3'b000, 7'b0, 1'b0, 1'b0, 1, 0, 0);
  endtask

  task automatic test_jal_disabled();
    reset_pulse();
    instr("jal_off", JL, 3'b000, 7'b0, 1'b0, 1'b0, 0, 0, 1);
    instr("jal_off_next", IT, 3'b000, 7'b0, 1'b0, 1'b0, 0, 0, 1);
    reset_pulse();
  endtask

  task automatic test_mid_reset();
    logic [8:0] got;
    opcode = LW; f3 = 3'b010; f7 = 7'b0;
    build(LW, 3'b010, 7'b0, 1'b0, 1'b0, 0, 3, 1'b1);
    run("mid_reset_pre", 0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    got = {bus_a.state, bus_a.memread, bus_a.memwrite, bus_a.pcwrite,
           bus_a.irwrite, bus_a.regwrite};
    total++;
    if (got !== 9'b0) begin
      bad++;
      $display("FAIL mid_reset: got=%b expected=%b", got, 9'b0);
    end
    exp_q.delete();
    ill_pending = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic random_instr(string name, int max_wait);
    logic [6:0] ops [7];
    logic [6:0] op;
    ops = '{LW, SW, RT, IT, BR, JL, BAD};
    op = ops[$urandom_range(0, 6)];
    instr(name, op, 3'($urandom), ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, max_wait), $urandom_range(0, max_wait), 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) random_instr("random", 3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) random_instr("back_to_back", 0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch();
    test_alu();
    test_jal();
    test_illegal();
    test_jal_disabled();
    test_mid_reset();
    test_random();
    test_back_to_back();
    instr("final", IT, 3'b000, 7'b0, 1'b0, 1'b0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_unit.md
# multicycle_ctrl_unit

Multi-cycle successor to the single-cycle control unit. A registered FSM sequences each RV32I instruction over 3–5 cycles through one shared memory port and one ALU, with memory wait-state handshaking. It sits between the instruction register and the multi-cycle datapath, and drives every enable and mux select. Compared with the single-cycle unit it adds JAL, all six conditional branches, and a parametrised ALU-control width.

## Interface
Parameters:
- ALUCTRL_W, 4: width of alucontrol.
- ENABLE_JAL, 1: 1 = decode JAL; 0 = treat opcode 1101111 as illegal.
- STATE_W, 4: width of the state debug output.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction-register opcode field.
- f3  in  3  funct3 field.
- f7  in  7  funct7 field.
- zero  in  1  ALU result == 0.
- lt  in  1  ALU comparison result, signed or unsigned per alucontrol.
- mem_ready  in  1  memory has completed the current access.
- pcwrite  out  1  PC register enable.
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALU-out register.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  instruction register and oldPC enable.
- regwrite  out  1  register-file write enable.
- resultsrc  out  2  result select: 00 = ALU-out register, 01 = data register, 10 = ALU result.
- alusrca  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
- alusrcb  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- immsrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alucontrol  out  ALUCTRL_W  ALU operation.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- state  out  STATE_W  current FSM state, for debug.

## Operation
- States:
  - FETCH: adrsrc=0, memread, irwrite, alusrca=00, alusrcb=10, add, resultsrc=10, pcwrite. The enables and writes take effect only in the cycle mem_ready=1.
  - DECODE: alusrca=01, alusrcb=01, add. Computes the branch/jump target.
  - MEMADR: alusrca=10, alusrcb=01, add.
  - MEMREAD: adrsrc=1, memread.
  - MEMWB: resultsrc=01, regwrite.
  - MEMWRITE: adrsrc=1, memwrite.
  - EXECR: alusrca=10, alusrcb=00, aludeco(R).
  - EXECI: alusrca=10, alusrcb=01, aludeco(I).
  - ALUWB: resultsrc=00, regwrite.
  - BRANCH: alusrca=10, alusrcb=00, resultsrc=00, compare op; pcwrite = taken.
  - JAL: alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite.
- Transitions:
  - FETCH→DECODE on mem_ready; otherwise hold in FETCH.
  - DECODE→MEMADR for lw/sw, EXECR for 0110011, EXECI for 0010011, BRANCH for 1100011, JAL for 1101111 (when ENABLE_JAL=1).
  - DECODE→FETCH on any other opcode, with illegal=1 for that one cycle.
  - MEMADR→MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD→MEMWB on mem_ready; MEMWB→FETCH.
  - MEMWRITE→FETCH on mem_ready.
  - EXECR/EXECI→ALUWB; ALUWB→FETCH; BRANCH→FETCH; JAL→ALUWB (writes rd = PC+4).
- Branch resolution by f3:
  - 000 beq: sub, taken=zero. 001 bne: sub, taken=!zero.
  - 100 blt: slt, taken=lt. 101 bge: slt, taken=!lt.
  - 110 bltu: sltu, taken=lt. 111 bgeu: sltu, taken=!lt.
  - 010/011: not taken, illegal=1.
- immsrc is decoded combinationally from opcode in every state.
- Any signal not listed for a state is 0.

## Timing
- Moore outputs decode from the registered state. The only Mealy terms are the mem_ready gating and pcwrite in BRANCH (taken uses same-cycle zero/lt).
- Cycles with mem_ready tied to 1: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4.
- Each low cycle of mem_ready in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- During a wait, memread/memwrite stay asserted with a stable address.
- With rst_n low: state=FETCH and pcwrite, irwrite, regwrite, memread, memwrite and illegal are all 0.
- The first memread is asserted in the first cycle after rst_n rises.
- Reset mid-instruction aborts it immediately; no write enable glitches.

## Structure
- ctrl_pkg holds: the state enum (FETCH=0 … JAL=10), opcode constants, alucontrol encodings (0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu), and aluop codes (00 add, 01 branch, 10 funct).
- Sub-module: the existing aludeco is reused for R-type and I-type funct decode. The FSM and branch logic live in multicycle_ctrl_unit.

## Test plan
- Reset then release, mem_ready=1, opcode 0000011 (lw) → states 0,1,2,3,4,0; regwrite=1 only in MEMWB; 5 cycles.
- sw with mem_ready low for 2 cycles in MEMWRITE → memwrite high for 3 cycles, adrsrc=1 throughout; FETCH follows.
- bne (f3=001), zero=0 → pcwrite=1 in BRANCH, alucontrol=0001; repeat with zero=1 → pcwrite=0.
- bgeu (f3=111), lt=0 → alucontrol=1001, pcwrite=1.
- jal with ENABLE_JAL=1 → JAL then ALUWB with pcwrite and regwrite in order; with ENABLE_JAL=0 → illegal pulse, return to FETCH.
- Opcode 1111111 → illegal=1 for one cycle, no write enable asserted; rst_n asserted in MEMREAD → state=0 asynchronously, memread=0.
